rr_stage: RTL and testbench

Register-read stage that sits directly upstream of the RR/EX pipeline register and drives its inputs. It holds the 8×32 architectural register file and a per-register pending-write scoreboard. It issues a decoded instruction to EX only when both sources are available, either from the file or bypassed from writeback; otherwise it stalls decode. It also absorbs writeback and flush-squash notifications so the scoreboard stays exact.

---
 rtl/rr_stage.sv | 101 ++++++++++
 tb/tb_rr_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stage.sv
// rtl/rr_stage.sv - register-read stage: 8x32 register file, pending-write scoreboard, operand bypass
module rr_stage (
    input  logic        clk,
    input  logic        rst_bar,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [2:0]  instr_length_in,
    input  logic [6:0]  ctrl_in,
    input  logic [2:0]  dst_idx_in,
    input  logic        dst_we_in,
    input  logic [2:0]  src1_idx_in,
    input  logic [2:0]  src2_idx_in,
    input  logic        src2_use_imm,
    input  logic [31:0] imm_in,
    input  logic        ex_stall,
    input  logic        flush,
    input  logic        sq_valid,
    input  logic [2:0]  sq_idx,
    input  logic        wb_valid,
    input  logic [2:0]  wb_idx,
    input  logic [31:0] wb_data,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [2:0]  instr_length_out,
    output logic [6:0]  ctrl_out,
    output logic [2:0]  dst_idx_out,
    output logic [31:0] src1_out,
    output logic [31:0] src2_out,
    output logic        stall_out
);

    logic [31:0] regs_q [8];
    logic [31:0] regs_d [8];
    logic [1:0]  cnt_q  [8];
    logic [1:0]  cnt_d  [8];

    logic        wb_hit1, wb_hit2;
    logic        hazard1, hazard2, sat, stall, issue;
    logic [31:0] src1_val, src2_val;

    // Decrements below zero are a protocol error; the counter clamps at 0.
    function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic inc,
                                             input logic dec_wb, input logic dec_sq);
        logic [2:0] sum;
        logic [2:0] sub;
        logic [2:0] diff;
        sum  = {1'b0, c} + {2'b00, inc};
        sub  = {2'b00, dec_wb} + {2'b00, dec_sq};
        diff = sum - sub;
        return (sum > sub) ? diff[1:0] : 2'd0;
    endfunction

    always_comb begin
        wb_hit1  = wb_valid && (wb_idx == src1_idx_in);
        wb_hit2  = wb_valid && (wb_idx == src2_idx_in);
        src1_val = wb_hit1 ? wb_data : regs_q[src1_idx_in];
        src2_val = wb_hit2 ? wb_data : regs_q[src2_idx_in];

        hazard1  = !((cnt_q[src1_idx_in] == 2'd0) ||
                     ((cnt_q[src1_idx_in] == 2'd1) && wb_hit1));
        hazard2  = !src2_use_imm &&
                   !((cnt_q[src2_idx_in] == 2'd0) ||
                     ((cnt_q[src2_idx_in] == 2'd1) && wb_hit2));
        sat      = dst_we_in && (cnt_q[dst_idx_in] == 2'd3);

        stall    = rst_bar && valid_in && (hazard1 || hazard2 || sat || ex_stall);
        issue    = rst_bar && valid_in && !stall && !flush;

        for (int i = 0; i < 8; i++) begin
            cnt_d[i]  = cnt_next(cnt_q[i],
                                 issue && dst_we_in && (dst_idx_in == 3'(i)),
                                 wb_valid && (wb_idx == 3'(i)),
                                 sq_valid && (sq_idx == 3'(i)));
            regs_d[i] = (wb_valid && (wb_idx == 3'(i))) ? wb_data : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 32'd0;
                cnt_q[i]  <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign valid_out        = issue;
    assign stall_out        = stall;
    assign pc_out           = pc_in;
    assign instr_length_out = instr_length_in;
    assign ctrl_out         = ctrl_in;
    assign dst_idx_out      = dst_idx_in;
    assign src1_out         = src1_val;
    assign src2_out         = src2_use_imm ? imm_in : src2_val;

endmodule

// File: tb/tb_rr_stage.sv
// tb/tb_rr_stage.sv - directed and randomized checks of rr_stage against a pending-write model
module tb_rr_stage;

    logic        clk = 1'b0;
    logic        rst_bar, valid_in, dst_we_in, src2_use_imm, ex_stall, flush;
    logic        sq_valid, wb_valid;
    logic [31:0] pc_in, imm_in, wb_data;
    logic [2:0]  instr_length_in, dst_idx_in, src1_idx_in, src2_idx_in, sq_idx, wb_idx;
    logic [6:0]  ctrl_in;
    logic        valid_out, stall_out;
    logic [31:0] pc_out, src1_out, src2_out;
    logic [2:0]  instr_length_out, dst_idx_out;
    logic [6:0]  ctrl_out;

    rr_stage dut (
        .clk(clk), .rst_bar(rst_bar), .valid_in(valid_in), .pc_in(pc_in),
        .instr_length_in(instr_length_in), .ctrl_in(ctrl_in), .dst_idx_in(dst_idx_in),
        .dst_we_in(dst_we_in), .src1_idx_in(src1_idx_in), .src2_idx_in(src2_idx_in),
        .src2_use_imm(src2_use_imm), .imm_in(imm_in), .ex_stall(ex_stall), .flush(flush),
        .sq_valid(sq_valid), .sq_idx(sq_idx), .wb_valid(wb_valid), .wb_idx(wb_idx),
        .wb_data(wb_data), .valid_out(valid_out), .pc_out(pc_out),
        .instr_length_out(instr_length_out), .ctrl_out(ctrl_out), .dst_idx_out(dst_idx_out),
        .src1_out(src1_out), .src2_out(src2_out), .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          pend [8];
    logic [31:0] file [8];
    logic        exp_issue, exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic src_ready(input logic [2:0] s);
        return (pend[s] == 0) || (pend[s] == 1 && wb_valid && wb_idx == s);
    endfunction

    function automatic logic [31:0] src_value(input logic [2:0] s);
        return (wb_valid && wb_idx == s) ? wb_data : file[s];
    endfunction

    // Evaluate the current inputs against the model and compare every output.
    task automatic settle(input string tag);
        logic blocked;
        #1;
        blocked   = !src_ready(src1_idx_in) || (!src2_use_imm && !src_ready(src2_idx_in)) ||
                    (dst_we_in && pend[dst_idx_in] >= 3) || ex_stall;
        exp_stall = rst_bar && valid_in && blocked;
        exp_issue = rst_bar && valid_in && !blocked && !flush;
        chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, exp_issue});
        chk({tag, ".stall"}, {31'd0, stall_out}, {31'd0, exp_stall});
        chk({tag, ".pass"}, {pc_out ^ {ctrl_out, dst_idx_out, instr_length_out, 19'd0}},
            {pc_in ^ {ctrl_in, dst_idx_in, instr_length_in, 19'd0}});
        if (rst_bar) begin
            chk({tag, ".src1"}, src1_out, src_value(src1_idx_in));
            chk({tag, ".src2"}, src2_out, src2_use_imm ? imm_in : src_value(src2_idx_in));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int r = 0; r < 8; r++) begin
            int c;
            if (!rst_bar) begin
                pend[r] = 0;
                file[r] = 32'd0;
            end else begin
                c = pend[r] + int'(exp_issue && dst_we_in && dst_idx_in == 3'(r))
                    - int'(wb_valid && wb_idx == 3'(r)) - int'(sq_valid && sq_idx == 3'(r));
                pend[r] = (c < 0) ? 0 : c;
                if (wb_valid && wb_idx == 3'(r)) file[r] = wb_data;
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        valid_in = 0; ex_stall = 0; flush = 0; sq_valid = 0; sq_idx = 0;
        wb_valid = 0; wb_idx = 0; wb_data = 0;
    endtask

    task automatic instr(input logic [2:0] dst, input logic we, input logic [2:0] s1,
                         input logic [2:0] s2, input logic use_imm, input logic [31:0] imm);
        valid_in = 1; pc_in = $urandom; instr_length_in = 3'($urandom);
        ctrl_in = 7'($urandom); dst_idx_in = dst; dst_we_in = we;
        src1_idx_in = s1; src2_idx_in = s2; src2_use_imm = use_imm; imm_in = imm;
    endtask

    task automatic wb(input logic [2:0] idx, input logic [31:0] data);
        wb_valid = 1; wb_idx = idx; wb_data = data;
    endtask

    initial begin
        logic hold;
        for (int r = 0; r < 8; r++) begin pend[r] = 0; file[r] = 0; end
        quiet();
        instr(3'd1, 1, 3'd2, 3'd3, 0, 32'd0);
        rst_bar = 0;
        @(negedge clk);
        settle("rst");
        chk("rst.valid0", {31'd0, valid_out}, 32'd0);
        chk("rst.stall0", {31'd0, stall_out}, 32'd0);
        tick(); tick();
        rst_bar = 1;

        // Preload r2=5, r3=7 through the normal issue/writeback path.
        instr(3'd2, 1, 3'd0, 3'd0, 1, 32'd0); settle("ld2"); tick();
        instr(3'd3, 1, 3'd0, 3'd0, 1, 32'd0); settle("ld3"); tick();
        quiet(); wb(3'd2, 32'd5); settle("wb2"); tick();
        quiet(); wb(3'd3, 32'd7); settle("wb3"); tick();
        quiet();

        instr(3'd4, 1, 3'd2, 3'd3, 0, 32'd0); settle("t1");
        chk("t1.issue", {31'd0, valid_out}, 32'd1);
        chk("t1.src1", src1_out, 32'd5);
        chk("t1.src2", src2_out, 32'd7);
        tick();

        instr(3'd1, 0, 3'd4, 3'd0, 1, 32'h11); settle("t2a");
        chk("t2.stall", {31'd0, stall_out}, 32'd1);
        tick();
        wb(3'd4, 32'hDEADBEEF); settle("t2b");
        chk("t2.bypass_issue", {31'd0, valid_out}, 32'd1);
        chk("t2.bypass_val", src1_out, 32'hDEADBEEF);
        tick(); quiet();
        instr(3'd1, 0, 3'd4, 3'd0, 1, 32'h11); settle("t2c");
        chk("t2.cnt4_zero", {31'd0, valid_out}, 32'd1);
        chk("t2.file4", src1_out, 32'hDEADBEEF);
        tick();

        for (int k = 0; k < 3; k++) begin
            instr(3'd6, 1, 3'd0, 3'd0, 1, 32'd0); settle("t3i");
            chk("t3.issue", {31'd0, valid_out}, 32'd1);
            tick();
        end
        instr(3'd6, 1, 3'd0, 3'd0, 1, 32'd0); settle("t3sat");
        chk("t3.sat", {31'd0, stall_out}, 32'd1);
        tick();
        wb(3'd6, 32'h66); settle("t3satwb");
        chk("t3.sat_wb", {31'd0, stall_out}, 32'd1);
        tick(); quiet();
        instr(3'd6, 1, 3'd0, 3'd0, 1, 32'd0); settle("t3go");
        chk("t3.after", {31'd0, valid_out}, 32'd1);
        tick(); quiet();
        for (int k = 0; k < 3; k++) begin wb(3'd6, 32'(k)); settle("t3drain"); tick(); end
        quiet();

        instr(3'd5, 1, 3'd0, 3'd0, 1, 32'd0); settle("t4a"); tick();
        instr(3'd5, 1, 3'd0, 3'd0, 1, 32'd0); sq_valid = 1; sq_idx = 3'd5; settle("t4b");
        chk("t4.issue_sq", {31'd0, valid_out}, 32'd1);
        tick(); quiet();
        wb(3'd5, 32'h55); settle("t4c"); tick(); quiet();
        instr(3'd0, 0, 3'd5, 3'd5, 0, 32'd0); settle("t4d");
        chk("t4.cnt5_zero", {31'd0, stall_out}, 32'd0);
        tick();

        instr(3'd7, 1, 3'd0, 3'd1, 0, 32'd0); flush = 1; settle("t5a");
        chk("t5.flush_valid", {31'd0, valid_out}, 32'd0);
        chk("t5.flush_stall", {31'd0, stall_out}, 32'd0);
        tick(); quiet();
        instr(3'd0, 0, 3'd7, 3'd7, 0, 32'd0); settle("t5b");
        chk("t5.no_inc", {31'd0, stall_out}, 32'd0);
        tick();

        instr(3'd2, 1, 3'd0, 3'd0, 1, 32'd0); settle("t6a"); tick();
        instr(3'd1, 1, 3'd0, 3'd0, 1, 32'd0); ex_stall = 1; settle("t6b");
        chk("t6.exstall", {31'd0, stall_out}, 32'd1);
        tick();
        rst_bar = 0; settle("t6rst");
        chk("t6.rst_stall", {31'd0, stall_out}, 32'd0);
        chk("t6.rst_valid", {31'd0, valid_out}, 32'd0);
        tick(); rst_bar = 1; quiet();
        instr(3'd0, 0, 3'd2, 3'd3, 0, 32'd0); settle("t6c");
        chk("t6.cleared_cnt", {31'd0, valid_out}, 32'd1);
        chk("t6.cleared_r2", src1_out, 32'd0);
        chk("t6.cleared_r3", src2_out, 32'd0);
        tick();

        // Random traffic that obeys the decode and writeback protocol.
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!hold) begin
                instr(3'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                      ($urandom % 3) == 0, $urandom);
                valid_in = ($urandom % 4) != 0;
            end
            rst_bar  = ($urandom % 80) != 0;
            ex_stall = ($urandom % 5) == 0;
            flush    = ($urandom % 10) == 0;
            wb_valid = 0; sq_valid = 0; wb_idx = 3'($urandom); sq_idx = 3'($urandom);
            wb_data  = $urandom;
            if (($urandom % 4) != 0) begin
                int off = $urandom % 8;
                for (int k = 0; k < 8; k++) begin
                    if (pend[(off + k) % 8] > 0) begin
                        wb(3'((off + k) % 8), $urandom);
                        break;
                    end
                end
            end
            if (($urandom % 6) == 0) begin
                int off = $urandom % 8;
                for (int k = 0; k < 8; k++) begin
                    int r = (off + k) % 8;
                    if (pend[r] - int'(wb_valid && wb_idx == 3'(r)) > 0) begin
                        sq_valid = 1; sq_idx = 3'(r);
                        break;
                    end
                end
            end
            settle("rnd");
            hold = exp_stall && !flush;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
